// File: rtl/a2_bus_timing_gen.sv
// rtl/a2_bus_timing_gen.sv - Apple IIe bus timing generator for the aux-slot DRAM interface
//
// Purpose: derives the system clocks, multiplexed DRAM strobes/address and
// slot selects from C14M. Each CPU cycle is 14 C14M ticks (T0..13). Every
// 65th cycle (N = 64) is stretched to 16 ticks (T0..15). T0..6 is the video
// half (PHI1) and T7..last is the CPU half (PHI0).
//
// Ports:
//   C14M     in   master clock, all state changes on its rising edge
//   nRES     in   asynchronous active-low reset
//   VID_A    in   video fetch address, latched at the edge entering T0
//   VID80    in   video fetch targets aux RAM, latched with VID_A
//   CPU_A    in   CPU address, latched at the edge entering T7
//   CPU_RnW  in   CPU read (1) / write (0), latched with CPU_A
//   CPU_AUX  in   CPU access targets aux RAM, latched with CPU_A
//   C7M, Q3, PHI0, PHI1   out  system clocks
//   nPRAS, nPCAS          out  DRAM row/column strobes
//   MA                    out  multiplexed DRAM row/column address
//   nWE, nWE80, nEN80, nC07X  out  slot write, aux write, aux enable, $C07x select
//   CPU_ACK               out  one-tick pulse in the last PHI0 tick

module a2_bus_timing_gen (
  input  logic        C14M,
  input  logic        nRES,
  input  logic [15:0] VID_A,
  input  logic        VID80,
  input  logic [15:0] CPU_A,
  input  logic        CPU_RnW,
  input  logic        CPU_AUX,
  output logic        C7M,
  output logic        Q3,
  output logic        PHI0,
  output logic        PHI1,
  output logic        nPRAS,
  output logic        nPCAS,
  output logic [7:0]  MA,
  output logic        nWE,
  output logic        nWE80,
  output logic        nEN80,
  output logic        nC07X,
  output logic        CPU_ACK
);

  // ST_RESET is the parked state after reset; the first edge out of it
  // loads T0, so reset itself is not counted as a tick.
  typedef enum logic {ST_RESET, ST_RUN} state_t;

  state_t      state;
  logic [3:0]  t;
  logic [6:0]  n;
  logic [15:0] va;
  logic [15:0] ca;
  logic        v80;
  logic        cw;
  logic        cx;

  // Next-tick state. Outputs are registered from these so that every output
  // reflects the tick being entered, including freshly latched addresses.
  logic [3:0]  t_nx;
  logic [6:0]  n_nx;
  logic [15:0] va_nx;
  logic [15:0] ca_nx;
  logic        v80_nx;
  logic        cw_nx;
  logic        cx_nx;
  logic [3:0]  last_tick;
  logic [3:0]  last_tick_nx;

  logic        c7m_nx;
  logic        q3_nx;
  logic        phi0_nx;
  logic        phi1_nx;
  logic        npras_nx;
  logic        npcas_nx;
  logic [7:0]  ma_nx;
  logic        nwe_nx;
  logic        nwe80_nx;
  logic        nen80_nx;
  logic        nc07x_nx;
  logic        ack_nx;

  assign last_tick = (n == 7'd64) ? 4'd15 : 4'd13;

  always_comb begin
    t_nx = 4'd0;
    n_nx = 7'd0;
    if (state == ST_RUN) begin
      if (t == last_tick) begin
        t_nx = 4'd0;
        n_nx = (n == 7'd64) ? 7'd0 : n + 7'd1;
      end else begin
        t_nx = t + 4'd1;
        n_nx = n;
      end
    end
  end

  always_comb begin
    va_nx  = va;
    v80_nx = v80;
    ca_nx  = ca;
    cw_nx  = cw;
    cx_nx  = cx;
    if (t_nx == 4'd0) begin
      va_nx  = VID_A;
      v80_nx = VID80;
    end
    if (t_nx == 4'd7) begin
      ca_nx = CPU_A;
      cw_nx = CPU_RnW;
      cx_nx = CPU_AUX;
    end
  end

  assign last_tick_nx = (n_nx == 7'd64) ? 4'd15 : 4'd13;

  always_comb begin
    c7m_nx   = ~t_nx[0];
    phi1_nx  = (t_nx <= 4'd6);
    phi0_nx  = (t_nx >= 4'd7);
    // Q3 stays low through the stretch ticks T14..15.
    q3_nx    = (t_nx <= 4'd3) || ((t_nx >= 4'd7) && (t_nx <= 4'd10));
    ack_nx   = (t_nx == last_tick_nx);
    ma_nx    = 8'h00;
    npras_nx = 1'b1;
    npcas_nx = 1'b1;
    nwe_nx   = 1'b1;
    nwe80_nx = 1'b1;
    nen80_nx = 1'b1;
    nc07x_nx = 1'b1;
    if (t_nx <= 4'd6) begin
      // Video half: row then column of the video address.
      ma_nx    = (t_nx <= 4'd3) ? va_nx[7:0] : va_nx[15:8];
      npras_nx = ~(t_nx >= 4'd2);
      npcas_nx = ~(t_nx >= 4'd4);
      nen80_nx = ~v80_nx;
    end else begin
      // CPU half: T7..8 precharge, RAS from T9, CAS and column from T11.
      ma_nx    = (t_nx <= 4'd10) ? ca_nx[7:0] : ca_nx[15:8];
      npras_nx = ~(t_nx >= 4'd9);
      npcas_nx = ~(t_nx >= 4'd11);
      if (t_nx >= 4'd9) begin
        nwe_nx   = cw_nx;
        nwe80_nx = ~(~cw_nx & cx_nx);
      end
      nen80_nx = ~cx_nx;
      nc07x_nx = ~(ca_nx[15:4] == 12'hC07);
    end
  end

  always_ff @(posedge C14M or negedge nRES) begin
    if (!nRES) begin
      state   <= ST_RESET;
      t       <= 4'd0;
      n       <= 7'd0;
      va      <= 16'h0000;
      ca      <= 16'h0000;
      v80     <= 1'b0;
      cw      <= 1'b1;
      cx      <= 1'b0;
      C7M     <= 1'b0;
      Q3      <= 1'b0;
      PHI0    <= 1'b0;
      PHI1    <= 1'b1;
      nPRAS   <= 1'b1;
      nPCAS   <= 1'b1;
      MA      <= 8'h00;
      nWE     <= 1'b1;
      nWE80   <= 1'b1;
      nEN80   <= 1'b1;
      nC07X   <= 1'b1;
      CPU_ACK <= 1'b0;
    end else begin
      state   <= ST_RUN;
      t       <= t_nx;
      n       <= n_nx;
      va      <= va_nx;
      ca      <= ca_nx;
      v80     <= v80_nx;
      cw      <= cw_nx;
      cx      <= cx_nx;
      C7M     <= c7m_nx;
      Q3      <= q3_nx;
      PHI0    <= phi0_nx;
      PHI1    <= phi1_nx;
      nPRAS   <= npras_nx;
      nPCAS   <= npcas_nx;
      MA      <= ma_nx;
      nWE     <= nwe_nx;
      nWE80   <= nwe80_nx;
      nEN80   <= nen80_nx;
      nC07X   <= nc07x_nx;
      CPU_ACK <= ack_nx;
    end
  end

endmodule

// File: tb/tb_a2_bus_timing_gen.sv
// tb/tb_a2_bus_timing_gen.sv - scoreboard bench for a2_bus_timing_gen

module tb_a2_bus_timing_gen;

  logic        C14M = 1'b0;
  logic        nRES = 1'b0;
  logic [15:0] VID_A = 16'h0000;
  logic        VID80 = 1'b0;
  logic [15:0] CPU_A = 16'h0000;
  logic        CPU_RnW = 1'b1;
  logic        CPU_AUX = 1'b0;
  logic        C7M, Q3, PHI0, PHI1, nPRAS, nPCAS;
  logic [7:0]  MA;
  logic        nWE, nWE80, nEN80, nC07X, CPU_ACK;

  a2_bus_timing_gen dut (
    .C14M(C14M), .nRES(nRES), .VID_A(VID_A), .VID80(VID80),
    .CPU_A(CPU_A), .CPU_RnW(CPU_RnW), .CPU_AUX(CPU_AUX),
    .C7M(C7M), .Q3(Q3), .PHI0(PHI0), .PHI1(PHI1),
    .nPRAS(nPRAS), .nPCAS(nPCAS), .MA(MA),
    .nWE(nWE), .nWE80(nWE80), .nEN80(nEN80), .nC07X(nC07X), .CPU_ACK(CPU_ACK)
  );

  always #5 C14M = ~C14M;

  // {C7M,Q3,PHI0,PHI1,nPRAS,nPCAS,MA,nWE,nWE80,nEN80,nC07X,CPU_ACK}
  logic [18:0] dut_vec;
  assign dut_vec = {C7M, Q3, PHI0, PHI1, nPRAS, nPCAS, MA, nWE, nWE80, nEN80, nC07X, CPU_ACK};
  localparam logic [18:0] RST_VEC = {4'b0001, 2'b11, 8'h00, 4'b1111, 1'b0};

  int errors = 0;
  int checks = 0;
  logic [18:0] sb[$];

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected outputs for one tick, straight from the timing rules.
  function automatic logic [18:0] exp_vec(input int t, input bit lng,
                                          input logic [15:0] va, input bit v80,
                                          input logic [15:0] ca, input bit cw, input bit cx);
    bit c7m, q3, phi0, phi1, pras, pcas, we, we80, en80, c07x, ack;
    logic [7:0] ma;
    bit vid;
    vid  = (t < 7);
    c7m  = (t % 2 == 0);
    phi1 = vid;
    phi0 = !vid;
    q3   = (t < 4) || (t >= 7 && t < 11);
    ack  = (t == (lng ? 15 : 13));
    if (vid) begin
      ma   = (t < 4) ? va[7:0] : va[15:8];
      pras = !(t >= 2);
      pcas = !(t >= 4);
      we   = 1; we80 = 1;
      en80 = !v80;
      c07x = 1;
    end else begin
      ma   = (t < 11) ? ca[7:0] : ca[15:8];
      pras = !(t >= 9);
      pcas = !(t >= 11);
      we   = (t >= 9) ? cw : 1'b1;
      we80 = (t >= 9) ? !(!cw && cx) : 1'b1;
      en80 = !cx;
      c07x = !(ca[15:4] == 12'hC07);
    end
    return {c7m, q3, phi0, phi1, pras, pcas, ma, we, we80, en80, c07x, ack};
  endfunction

  // Reference model: absolute tick count since reset release, folded into
  // the 912-tick frame of 64 normal cycles plus one long cycle.
  int g = 0;
  bit in_reset = 1;
  int cur_t = -1;
  logic [15:0] m_va = 0, m_ca = 0;
  bit m_v80 = 0, m_cw = 1, m_cx = 0;

  always @(posedge C14M) begin
    int p, t;
    bit lng;
    if (!nRES) begin
      in_reset = 1;
      cur_t = -1;
      sb.push_back(RST_VEC);
    end else begin
      if (in_reset) begin g = 0; in_reset = 0; end
      else g++;
      p = g % 912;
      if (p < 896) begin t = p % 14; lng = 0; end
      else begin t = p - 896; lng = 1; end
      if (t == 0) begin m_va = VID_A; m_v80 = VID80; end
      if (t == 7) begin m_ca = CPU_A; m_cw = CPU_RnW; m_cx = CPU_AUX; end
      cur_t = t;
      sb.push_back(exp_vec(t, lng, m_va, m_v80, m_ca, m_cw, m_cx));
    end
  end

  // Monitor: compares at the falling edge, well away from the active edge.
  always @(negedge C14M) begin
    logic [18:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("tick", dut_vec, e);
    end
  end

  task automatic run_ticks(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge C14M);
      #2;
      if (rnd) begin
        VID_A   = 16'($urandom);
        VID80   = 1'($urandom);
        CPU_A   = ($urandom_range(0, 3) == 0) ? (16'hC070 | 16'($urandom_range(0, 15)))
                                              : 16'($urandom);
        CPU_RnW = 1'($urandom);
        CPU_AUX = 1'($urandom);
      end
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge C14M);
    @(negedge C14M);
    #1 check("reset_state", dut_vec, RST_VEC);
    nRES = 1'b1;

    // Idle: CPU reads, main RAM.
    run_ticks(28, 0);

    // Aux write to $2345 with an aux video fetch from $0400.
    VID_A = 16'h0400; VID80 = 1'b1;
    CPU_A = 16'h2345; CPU_RnW = 1'b0; CPU_AUX = 1'b1;
    run_ticks(28, 0);

    // Main write to $C073.
    VID80 = 1'b0;
    CPU_A = 16'hC073; CPU_RnW = 1'b0; CPU_AUX = 1'b0;
    run_ticks(28, 0);

    // Random traffic across the long-cycle wrap.
    run_ticks(1000, 1);

    // Asynchronous reset at T10 of a write cycle.
    CPU_A = 16'h2345; CPU_RnW = 1'b0; CPU_AUX = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge C14M);
      #1;
      if (cur_t == 10) found = 1;
    end
    check("reset_wait_t10", {18'h0, found}, 19'h1);
    @(negedge C14M);
    #1 nRES = 1'b0;
    #1 check("async_reset", dut_vec, RST_VEC);
    repeat (2) @(posedge C14M);
    @(negedge C14M);
    #1 nRES = 1'b1;

    // Restart from T0; first long cycle comes 64 cycles later.
    run_ticks(950, 1);
    @(negedge C14M);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/a2_bus_timing_gen.md
# a2_bus_timing_gen

Apple IIe-side memory-bus timing generator: the initiator for the auxiliary-slot DRAM interface that the RAM expansion CPLD responds to. From C14M it derives C7M, Q3, PHI0/PHI1, the multiplexed DRAM strobes nPRAS/nPCAS, the row/column address MA, and the slot selects nWE, nWE80, nEN80 and nC07X, including the stretched "long" CPU cycle. It drives the expansion card during bring-up and in simulation benches, and it replaces discrete Apple IIe timing logic in a standalone board.

## Interface
- No parameters; all timing below is fixed.
- C14M  in  1  14.318 MHz master clock; all state changes on its rising edge.
- nRES  in  1  Asynchronous active-low reset.
- VID_A  in  16  Video fetch address; sampled at the start of PHI1.
- VID80  in  1  1 = the current video fetch targets auxiliary RAM; sampled with VID_A.
- CPU_A  in  16  CPU address; sampled at the start of PHI0.
- CPU_RnW  in  1  1 = read, 0 = write; sampled with CPU_A.
- CPU_AUX  in  1  1 = the CPU access targets auxiliary RAM; sampled with CPU_A.
- C7M, Q3, PHI0, PHI1  out  1 each  System clocks.
- nPRAS, nPCAS  out  1 each  DRAM row/column strobes.
- MA  out  8  Multiplexed DRAM address.
- nWE, nWE80, nEN80, nC07X  out  1 each  Slot write, aux write, aux enable, and $C07x select.
- CPU_ACK  out  1  One-tick pulse in the last PHI0 tick; the CPU completes its data transfer on this tick.

## Operation
- Tick counter T counts C14M ticks within a CPU cycle. Normal cycle: T = 0..13. Long cycle: T = 0..15.
- Cycle counter N runs 0..64. Cycle N = 64 is long; N wraps to 0 after it.
- All outputs are registered. "During tick k" means the C14M period that begins at the edge which loads T = k.
- C7M = 1 on even T. In a long cycle it continues to toggle every tick.
- PHI1 = 1 for T0..6. PHI0 = 1 for T7 through the last tick.
- Q3 = 1 for T0..3 and T7..10. Q3 = 0 otherwise, including T14..15.
- Video half (PHI1):
  - VID_A and VID80 are latched into VA/V80 at the edge entering T0.
  - MA = VA[7:0] for T0..3 and VA[15:8] for T4..6.
  - nPRAS = 0 for T2..6. nPCAS = 0 for T4..6.
  - nEN80 = ~V80 for T0..6.
  - nWE = 1, nWE80 = 1, nC07X = 1.
- CPU half (PHI0):
  - CPU_A, CPU_RnW and CPU_AUX are latched into CA/CW/CX at the edge entering T7.
  - MA = CA[7:0] for T7..10 and CA[15:8] from T11 to the last tick.
  - nPRAS = 0 from T9 to the last tick. nPCAS = 0 from T11 to the last tick.
  - nWE = CW for T9 to the last tick; nWE = 1 otherwise.
  - nWE80 = ~(~CW & CX) over the same window.
  - nEN80 = ~CX for T7 to the last tick.
  - nC07X = ~(CA[15:4] == 12'hC07) for T7 to the last tick.
  - CPU_ACK = 1 only in the last tick: T13, or T15 when long.
- Boundary conditions:
  - Inputs that change mid-half have no effect until the next latch edge.
  - Wrap: the last tick of cycle 64 is followed by T0 with N = 0.

## Timing
- Reset asserted: T = 0, N = 0, VA = CA = 0, V80 = CX = 0, CW = 1.
- Output values while in reset:
  - PHI1 = 1, PHI0 = 0, C7M = 0, Q3 = 0.
  - nPRAS = nPCAS = 1, MA = 0.
  - nWE = nWE80 = nEN80 = nC07X = 1, CPU_ACK = 0.
- Reset released: the first rising C14M loads T0 with N = 0. The first PHI1→PHI0 edge occurs at the edge entering T7.
- Reset asserted mid-cycle: all outputs go to their reset values immediately (asynchronous). No partial strobe is extended.
- Latency: address sample to first MA row value is 0 ticks, because MA is driven from the newly latched value in the same tick.
- Strobe order within each half: row address, then nPRAS low, then column address with nPCAS low. Both strobes rise together at the end of the half.
- nPRAS is high for exactly T0..1 and T7..8 in every cycle. This guarantees precharge before each half.
- Period check: 65 cycles = 64×14 + 16 = 912 ticks.

## Test plan
- Reset release, idle inputs: PHI1 high for 7 ticks, then PHI0 high for 7 ticks. nPRAS low T2..6 and T9..13. nPCAS low T4..6 and T11..13. CPU_ACK pulses at T13.
- Long cycle: count 64 normal cycles, then a 16-tick cycle with PHI0 high T7..15 and CPU_ACK at T15. Total 912 ticks between every 65th PHI1 rise.
- CPU write, CPU_A = 16'h2345, CPU_RnW = 0, CPU_AUX = 1:
  - MA = 8'h45 for T7..10, then 8'h23 for T11..13.
  - nWE = nWE80 = 0 for T9..13. nEN80 = 0 for T7..13.
- CPU write to $C073 with CPU_AUX = 0: nC07X = 0 for T7..13, nWE = 0 for T9..13, nWE80 = 1, nEN80 = 1.
- Video fetch with VID_A = 16'h0400 and VID80 = 1: MA = 8'h00 for T0..3, then 8'h04 for T4..6. nEN80 = 0 for T0..6. nWE = 1.
- Assert nRES at T10 of a write cycle: all strobes go high in the same tick. After release, the sequence restarts at T0 and the first long cycle comes 64 cycles later.
